// File: rtl/vga_cmd_arbiter_if.sv
// Command-side bundle of vga_cmd_arbiter: two byte requesters in, one paced byte stream out.
interface vga_cmd_arbiter_if;
    logic [7:0] d0;
    logic       d0v;
    logic [7:0] d1;
    logic       d1v;
    logic       en1;
    logic       ready;
    logic       errClr;
    logic [7:0] od;
    logic       odv;
    logic       error;
    logic       locked;

    modport master (
        output d0, d0v, d1, d1v, en1, ready, errClr,
        input  od, odv, error, locked
    );

    modport slave (
        input  d0, d0v, d1, d1v, en1, ready, errClr,
        output od, odv, error, locked
    );
endinterface

// File: rtl/vga_cmd_arbiter.sv
// Merges ANSI stream (ch0) and keyboard echo (ch1) into one VGA command strobe, keeping escape sequences atomic.
// Latency: write strobe to odv is 2 cycles minimum; odv pulses are at least GAP+1 cycles apart.
// Backpressure: ready=0 stalls pops only; writes into a full FIFO are dropped and raise sticky error.
module vga_cmd_arbiter #(
    parameter int DEPTH        = 8,
    parameter int GAP          = 2,
    parameter int LOCK_TIMEOUT = 4096
) (
    input logic             clk,
    input logic             resetn,
    vga_cmd_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ESC0 = 3'd1;
    localparam logic [2:0] CSI0 = 3'd2;
    localparam logic [2:0] ESC1 = 3'd3;
    localparam logic [2:0] CSI1 = 3'd4;

    logic [7:0]    mem [2][DEPTH];
    logic [AW-1:0] wp [2];
    logic [AW-1:0] rp [2];
    logic [AW:0]   cnt [2];

    logic [2:0]    state, nxtState;
    logic [GW-1:0] gapCnt;
    logic [TW-1:0] toCnt;
    logic          lastCh;
    logic [7:0]    odQ;
    logic          odvQ, errQ, lockQ;

    logic          wrV [2];
    logic [7:0]    wrD [2];
    logic          accept [2];
    logic          doPop [2];
    logic          nonEmp0, nonEmp1, selCh, selOk, pop, ovf;
    logic [7:0]    popByte;

    always_comb begin
        wrV[0]  = bus.d0v;
        wrV[1]  = bus.d1v & bus.en1;
        wrD[0]  = bus.d0;
        wrD[1]  = bus.d1;
        nonEmp0 = (cnt[0] != '0);
        nonEmp1 = (cnt[1] != '0);
        selCh   = 1'b0;
        selOk   = 1'b0;
        // While a sequence is open only its owner may be served.
        case (state)
            ESC0, CSI0: begin selCh = 1'b0; selOk = nonEmp0; end
            ESC1, CSI1: begin selCh = 1'b1; selOk = nonEmp1; end
            default: begin
                if (nonEmp0 && nonEmp1) selCh = ~lastCh;
                else                    selCh = nonEmp1;
                selOk = nonEmp0 | nonEmp1;
            end
        endcase
        pop     = bus.ready && (gapCnt == '0) && selOk;
        popByte = mem[selCh][rp[selCh]];
        ovf     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            doPop[c]  = pop && (selCh == c[0]);
            accept[c] = wrV[c] && ((cnt[c] != (AW+1)'(DEPTH)) || doPop[c]);
            ovf       = ovf | (wrV[c] & ~accept[c]);
        end
    end

    always_comb begin
        nxtState = state;
        if (pop) begin
            case (state)
                IDLE:       if (popByte == 8'h1B) nxtState = selCh ? ESC1 : ESC0;
                ESC0, ESC1: if (popByte == 8'h5B)      nxtState = (state == ESC0) ? CSI0 : CSI1;
                            else if (popByte != 8'h1B) nxtState = IDLE;
                CSI0, CSI1: if (popByte >= 8'h40 && popByte <= 8'h7E) nxtState = IDLE;
                default:    nxtState = IDLE;
            endcase
        end else if (state != IDLE && toCnt >= TW'(LOCK_TIMEOUT - 1)) begin
            nxtState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            if (accept[c]) mem[c][wp[c]] <= wrD[c];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < 2; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (accept[c]) wp[c] <= wp[c] + 1'b1;
                if (doPop[c])  rp[c] <= rp[c] + 1'b1;
                cnt[c] <= cnt[c] + (AW+1)'(accept[c]) - (AW+1)'(doPop[c]);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            gapCnt <= '0;
            toCnt  <= '0;
            lastCh <= 1'b1;
            odQ    <= 8'h00;
            odvQ   <= 1'b0;
            errQ   <= 1'b0;
            lockQ  <= 1'b0;
        end else begin
            state <= nxtState;
            lockQ <= (nxtState != IDLE);
            odvQ  <= pop;
            odQ   <= pop ? popByte : 8'h00;
            if (pop) lastCh <= selCh;

            if (pop)                gapCnt <= GW'(GAP);
            else if (gapCnt != '0)  gapCnt <= gapCnt - 1'b1;

            if (pop || nxtState == IDLE)                toCnt <= '0;
            else if (toCnt < TW'(LOCK_TIMEOUT))         toCnt <= toCnt + 1'b1;

            if (ovf)              errQ <= 1'b1;
            else if (bus.errClr)  errQ <= 1'b0;
        end
    end

    assign bus.od     = odQ;
    assign bus.odv    = odvQ;
    assign bus.error  = errQ;
    assign bus.locked = lockQ;
endmodule

// File: tb/tb_vga_cmd_arbiter.sv
// Directed bench for vga_cmd_arbiter with a queue-based reference model compared every cycle.
module tb_vga_cmd_arbiter;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int LT    = 20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vga_cmd_arbiter_if bus();

    vga_cmd_arbiter #(.DEPTH(DEPTH), .GAP(GAP), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: per-channel byte queues, lock owner, gap and timeout counts.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int   owner, gap, tmo, last, ch;
    bit   inCsi, popNow, ovf, acc0, acc1;
    logic [7:0] b;
    logic [7:0] mOd;
    bit   mOdv, mErr, mLock;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q0.delete(); q1.delete();
            owner = -1; inCsi = 0; gap = 0; tmo = 0; last = 1;
            mOd = 8'h00; mOdv = 0; mErr = 0; mLock = 0;
        end else begin
            ch = -1;
            if (owner == 0)      begin if (q0.size() > 0) ch = 0; end
            else if (owner == 1) begin if (q1.size() > 0) ch = 1; end
            else if (q0.size() > 0 && q1.size() > 0) ch = 1 - last;
            else if (q0.size() > 0) ch = 0;
            else if (q1.size() > 0) ch = 1;
            popNow = bus.ready && gap == 0 && ch >= 0;
            acc0 = bus.d0v && (q0.size() < DEPTH || (popNow && ch == 0));
            acc1 = bus.d1v && bus.en1 && (q1.size() < DEPTH || (popNow && ch == 1));
            ovf  = (bus.d0v && !acc0) || (bus.d1v && bus.en1 && !acc1);
            b = 8'h00;
            if (popNow) begin
                b = (ch == 0) ? q0.pop_front() : q1.pop_front();
                last = ch;
            end
            if (acc0) q0.push_back(bus.d0);
            if (acc1) q1.push_back(bus.d1);
            if (popNow) begin
                tmo = 0;
                if (owner < 0) begin
                    if (b == 8'h1B) begin owner = ch; inCsi = 0; end
                end else if (!inCsi) begin
                    if (b == 8'h5B) inCsi = 1;
                    else if (b != 8'h1B) owner = -1;
                end else if (b >= 8'h40 && b <= 8'h7E) begin
                    owner = -1;
                end
            end else if (owner >= 0) begin
                tmo++;
                if (tmo >= LT) begin owner = -1; tmo = 0; end
            end
            if (popNow) gap = GAP; else if (gap > 0) gap--;
            mOdv  = popNow;
            mOd   = b;
            mLock = (owner >= 0);
            if (ovf) mErr = 1; else if (bus.errClr) mErr = 0;
        end
    end

    logic [7:0] outB[$];
    int         outC[$];
    bit         outL[$];

    always @(negedge clk) begin
        if (resetn) begin
            chk("odv", {31'b0, bus.odv}, {31'b0, mOdv});
            if (mOdv) chk("od", {24'b0, bus.od}, {24'b0, mOd});
            chk("error", {31'b0, bus.error}, {31'b0, mErr});
            chk("locked", {31'b0, bus.locked}, {31'b0, mLock});
            if (bus.odv) begin
                outB.push_back(bus.od);
                outC.push_back(cyc);
                outL.push_back(bus.locked);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        outB.delete(); outC.delete(); outL.delete();
    endtask

    task automatic doReset();
        resetn = 1'b0;
        bus.d0 = 8'h00; bus.d0v = 1'b0; bus.d1 = 8'h00; bus.d1v = 1'b0;
        bus.en1 = 1'b1; bus.ready = 1'b0; bus.errClr = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(2);
        clearLog();
    endtask

    task automatic wr0(input logic [7:0] v);
        bus.d0 = v; bus.d0v = 1'b1; tick(1); bus.d0v = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] v);
        bus.d1 = v; bus.d1v = 1'b1; tick(1); bus.d1v = 1'b0;
    endtask

    task automatic waitLog(input int n, input int budget);
        int k = 0;
        while (outB.size() < n && k < budget) begin tick(1); k++; end
        if (outB.size() < n) chk("wait_strobes", outB.size(), n);
    endtask

    task automatic expSeq(input string nm, input logic [7:0] e[], input int n);
        chk({nm, "_count"}, outB.size(), n);
        for (int i = 0; i < n && i < outB.size(); i++) chk(nm, {24'b0, outB[i]}, {24'b0, e[i]});
    endtask

    int T, p;
    logic [7:0] e[];

    initial begin
        bus.d0 = 8'h00; bus.d0v = 1'b0; bus.d1 = 8'h00; bus.d1v = 1'b0;
        bus.en1 = 1'b1; bus.ready = 1'b0; bus.errClr = 1'b0;
        tick(2);
        chk("rst_od", {24'b0, bus.od}, 32'h0);
        chk("rst_odv", {31'b0, bus.odv}, 32'h0);
        chk("rst_error", {31'b0, bus.error}, 32'h0);
        chk("rst_locked", {31'b0, bus.locked}, 32'h0);

        // Single byte: 2-cycle latency; a disabled ch1 strobe is ignored silently.
        doReset();
        bus.ready = 1'b1;
        T = cyc;
        wr0(8'h41);
        waitLog(1, 10);
        if (outC.size() > 0) chk("single_latency", outC[0] - T, 2);
        e = '{8'h41};
        expSeq("single_byte", e, 1);
        bus.en1 = 1'b0;
        wr1(8'h99);
        tick(8);
        chk("en1_ignored", outB.size(), 1);
        chk("en1_no_error", {31'b0, bus.error}, 32'h0);
        bus.en1 = 1'b1;

        // Interleave: three bytes each side, round-robin from ch0, GAP+1 spacing.
        doReset();
        for (int i = 0; i < 3; i++) begin
            bus.d0 = 8'hA0 + 8'(i); bus.d1 = 8'hB0 + 8'(i);
            bus.d0v = 1'b1; bus.d1v = 1'b1;
            tick(1);
        end
        bus.d0v = 1'b0; bus.d1v = 1'b0;
        bus.ready = 1'b1;
        waitLog(6, 40);
        e = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        expSeq("interleave", e, 6);
        for (int i = 0; i + 1 < outC.size(); i++) chk("interleave_spacing", outC[i+1] - outC[i], 3);

        // Atomic CSI: echo byte arrives mid-sequence and must wait.
        doReset();
        wr0(8'h1B); wr0(8'h5B); wr0(8'h33); wr0(8'h31); wr0(8'h6D);
        bus.ready = 1'b1;
        waitLog(1, 10);
        wr1(8'h78);
        waitLog(6, 60);
        e = '{8'h1B, 8'h5B, 8'h33, 8'h31, 8'h6D, 8'h78};
        expSeq("csi_order", e, 6);
        if (outL.size() >= 6) begin
            chk("csi_lock_1B", {31'b0, outL[0]}, 32'h1);
            chk("csi_lock_31", {31'b0, outL[3]}, 32'h1);
            chk("csi_lock_6D", {31'b0, outL[4]}, 32'h0);
            chk("csi_lock_x",  {31'b0, outL[5]}, 32'h0);
        end

        // Overflow: DEPTH+1 writes while stalled.
        doReset();
        for (int i = 0; i <= DEPTH; i++) wr0(8'h10 + 8'(i));
        chk("ovf_error", {31'b0, bus.error}, 32'h1);
        bus.ready = 1'b1;
        tick(40);
        e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        expSeq("ovf_drain", e, DEPTH);
        bus.errClr = 1'b1; tick(1); bus.errClr = 1'b0;
        chk("ovf_errclr", {31'b0, bus.error}, 32'h0);

        // Lock timeout releases a stalled escape.
        doReset();
        bus.ready = 1'b1;
        wr0(8'h1B);
        waitLog(1, 10);
        wr1(8'h79);
        waitLog(2, LT + 10);
        if (outC.size() >= 2) begin
            p = outC[0];
            chk("timeout_delay", outC[1] - p, LT + 1);
            chk("timeout_byte", {24'b0, outB[1]}, 32'h79);
            chk("timeout_unlocked", {31'b0, outL[1]}, 32'h0);
        end

        // Reset while inside CSI0 with both FIFOs holding data.
        doReset();
        wr0(8'h1B); wr0(8'h5B); wr0(8'h33);
        wr1(8'h7A);
        bus.ready = 1'b1;
        waitLog(2, 20);
        chk("csi0_locked", {31'b0, bus.locked}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("midrst_od", {24'b0, bus.od}, 32'h0);
        chk("midrst_odv", {31'b0, bus.odv}, 32'h0);
        chk("midrst_locked", {31'b0, bus.locked}, 32'h0);
        chk("midrst_error", {31'b0, bus.error}, 32'h0);
        tick(2);
        resetn = 1'b1;
        clearLog();
        tick(15);
        chk("midrst_silent", outB.size(), 0);
        wr0(8'h55);
        waitLog(1, 10);
        e = '{8'h55};
        expSeq("midrst_new", e, 1);

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
